rotor_stage: RTL

Clocked, parametrised Enigma rotor stage with both signal directions in one block: forward (keyboard→reflector) and inverse (reflector→lamp) paths. It holds its own rotor position and ring setting, steps on command, and reports turnover to the next rotor. Each path is registered with a valid strobe. Three instances form the rotor stack between the plugboard and reflector. The stepping controller drives `step_in` and chains `carry_out` and `at_notch`.

---
 rtl/rotor_if.sv | 34 +++
 rtl/rotor_stage.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/rotor_if.sv
// Bus bundle for one rotor stage: load/step control, the two letter paths,
// and the position/turnover status seen by the stepping controller.
interface rotor_if;
    logic       load_en;
    logic [4:0] load_pos;
    logic [4:0] load_ring;
    logic       step_in;
    logic       fwd_valid_in;
    logic [4:0] fwd_in;
    logic       inv_valid_in;
    logic [4:0] inv_in;
    logic       fwd_valid_out;
    logic [4:0] fwd_out;
    logic       inv_valid_out;
    logic [4:0] inv_out;
    logic       err;
    logic [4:0] pos;
    logic       at_notch;
    logic       carry_out;

    modport master (
        output load_en, load_pos, load_ring, step_in,
               fwd_valid_in, fwd_in, inv_valid_in, inv_in,
        input  fwd_valid_out, fwd_out, inv_valid_out, inv_out,
               err, pos, at_notch, carry_out
    );

    modport slave (
        input  load_en, load_pos, load_ring, step_in,
               fwd_valid_in, fwd_in, inv_valid_in, inv_in,
        output fwd_valid_out, fwd_out, inv_valid_out, inv_out,
               err, pos, at_notch, carry_out
    );
endinterface

// File: rtl/rotor_stage.sv
// Enigma rotor stage: registered forward and inverse substitution paths
// sharing one rotor position/ring state, plus stepping and turnover.
module rotor_stage #(
    parameter int ROTOR_SEL = 1,
    parameter int INIT_POS  = 0,
    parameter int INIT_RING = 0
) (
    input  logic   clk,
    input  logic   rst_n,
    rotor_if.slave bus
);
    typedef logic [25:0][4:0] table_t;

    if (ROTOR_SEL < 1 || ROTOR_SEL > 5) begin : g_bad_sel
        $error("rotor_stage: ROTOR_SEL must be 1..5");
    end

    // Wiring strings hold one ASCII letter per contact, contact 0 in the MSB byte.
    function automatic table_t build_fwd(input int sel);
        logic [26*8-1:0] s;
        table_t          t;
        case (sel)
            1:       s = "EKMFLGDQVZNTOWYHXPRCSUAIBJ";
            2:       s = "AJDKSIRUXBLHWTMCQGZNPYFVOE";
            3:       s = "BDFHJLCPRTXVZNYEIWGAKMUSQO";
            4:       s = "ESOVPZJAYQUIRHXLNFTGKDCMWB";
            5:       s = "VZBRGITYUPSDNHLXAWMKFQOCJE";
            default: s = "ABCDEFGHIJKLMNOPQRSTUVWXYZ";
        endcase
        for (int i = 0; i < 26; i++) t[i] = 5'(s[(25-i)*8 +: 8] - 8'd65);
        return t;
    endfunction

    function automatic table_t build_inv(input table_t f);
        table_t t;
        t = '0;
        for (int i = 0; i < 26; i++) t[f[i]] = 5'(i);
        return t;
    endfunction

    function automatic logic [4:0] notch_of(input int sel);
        case (sel)
            1:       return 5'd16;
            2:       return 5'd4;
            3:       return 5'd21;
            4:       return 5'd9;
            default: return 5'd25;
        endcase
    endfunction

    localparam table_t     FWD   = build_fwd(ROTOR_SEL);
    localparam table_t     INV   = build_inv(FWD);
    localparam logic [4:0] NOTCH = notch_of(ROTOR_SEL);

    // Offset-in / table / offset-out substitution; every step stays below 52.
    function automatic logic [4:0] map_letter(input table_t w, input logic [4:0] l,
                                              input logic [5:0] s);
        logic [5:0] idx;
        logic [5:0] wv;
        logic [5:0] o;
        idx = {1'b0, l} - 6'd1 + s;
        if (idx >= 6'd26) idx = idx - 6'd26;
        wv = {1'b0, w[idx[4:0]]};
        o  = (wv >= s) ? wv - s : wv + 6'd26 - s;
        return o[4:0] + 5'd1;
    endfunction

    function automatic logic in_range(input logic [4:0] l);
        return (l >= 5'd1) && (l <= 5'd26);
    endfunction

    function automatic logic [4:0] mod26(input logic [4:0] v);
        return (v > 5'd25) ? v - 5'd26 : v;
    endfunction

    logic [4:0] pos_r, ring_r, nxt_pos, nxt_ring;
    logic       at_notch_r, carry_r, nxt_carry;
    logic       fwd_v_r, inv_v_r, err_r;
    logic [4:0] fwd_r, inv_r;
    logic [5:0] shift;
    logic       fwd_ok, inv_ok;

    // Rotor offset seen by the datapath this cycle (pre-step, pre-load).
    always_comb begin
        shift  = (pos_r >= ring_r) ? {1'b0, pos_r} - {1'b0, ring_r}
                                   : {1'b0, pos_r} + 6'd26 - {1'b0, ring_r};
        fwd_ok = in_range(bus.fwd_in);
        inv_ok = in_range(bus.inv_in);
    end

    // Letter pipelines: one-cycle registered result; data holds while idle.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register sampling pre-edge values.
        if (!rst_n) begin
            fwd_v_r <= 1'b0;
            inv_v_r <= 1'b0;
            fwd_r   <= '0;
            inv_r   <= '0;
            err_r   <= 1'b0;
        end else begin
            fwd_v_r <= bus.fwd_valid_in;
            inv_v_r <= bus.inv_valid_in;
            if (bus.fwd_valid_in) fwd_r <= fwd_ok ? map_letter(FWD, bus.fwd_in, shift) : 5'd0;
            if (bus.inv_valid_in) inv_r <= inv_ok ? map_letter(INV, bus.inv_in, shift) : 5'd0;
            err_r <= (bus.fwd_valid_in && !fwd_ok) || (bus.inv_valid_in && !inv_ok);
        end
    end

    // Next rotor state: load beats step, step beats hold.
    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        nxt_pos   = pos_r;
        nxt_ring  = ring_r;
        nxt_carry = 1'b0;
        if (bus.load_en) begin
            nxt_pos  = mod26(bus.load_pos);
            nxt_ring = mod26(bus.load_ring);
        end else if (bus.step_in) begin
            nxt_pos   = (pos_r == 5'd25) ? 5'd0 : pos_r + 5'd1;
            nxt_carry = (pos_r == NOTCH);
        end
    end

    // Rotor state register; at_notch tracks the registered position.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pos_r      <= 5'(INIT_POS);
            ring_r     <= 5'(INIT_RING);
            at_notch_r <= (5'(INIT_POS) == NOTCH);
            carry_r    <= 1'b0;
        end else begin
            pos_r      <= nxt_pos;
            ring_r     <= nxt_ring;
            at_notch_r <= (nxt_pos == NOTCH);
            carry_r    <= nxt_carry;
        end
    end

    assign bus.fwd_valid_out = fwd_v_r;
    assign bus.fwd_out       = fwd_r;
    assign bus.inv_valid_out = inv_v_r;
    assign bus.inv_out       = inv_r;
    assign bus.err           = err_r;
    assign bus.pos           = pos_r;
    assign bus.at_notch      = at_notch_r;
    assign bus.carry_out     = carry_r;
endmodule
